// File: rtl/mul_div_controller.sv
// mul_div_controller
//   Sequences the multiply/divide resource beside the ALU in the Execute stage.
//   This block owns the architectural HI/LO registers. It drives an external
//   fixed-latency unsigned multiplier and an unsigned AXI-stream divider. Both
//   units only ever see operand magnitudes. This block applies the sign to the
//   operands before each operation and to the result after it.
//
// Parameters
//   MUL_LATENCY     : cycles from operand presentation to a valid Mul_p (0..15)
//   DIV_FLUSH_DRAIN : 1 = after a flush, swallow the next divider result
//
// Ports
//   clock, reset_n              : rising-edge clock, async active-low reset
//   Start_mul / Start_div       : mult(u) / div(u) in EX this cycle
//   Signed_op                   : 1 = signed mult/div
//   Operand_a / Operand_b       : forwarded rs / rt
//   Mthi, Mtlo, Mfhi, Mflo      : HI/LO move instructions in EX
//   Flush                       : kill EX instruction, abort in-flight op
//   Mul_a, Mul_b, Mul_p         : external multiplier operands / product
//   Div_tvalid                  : operand valid for dividend and divisor
//   Div_dividend, Div_divisor   : divider magnitude operands
//   Div_dout_tvalid/_tdata      : divider result {quotient, remainder}
//   Hi, Lo                      : architectural registers
//   Hilo_read_data              : Hi on Mfhi, Lo on Mflo, else 0
//   Stall                       : hold IF/ID/EX
//   Busy                        : an operation is outstanding
//   Divide_zero                 : one-cycle pulse on divide by zero
module mul_div_controller #(
   parameter int unsigned MUL_LATENCY     = 3,
   parameter bit          DIV_FLUSH_DRAIN = 1'b1
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        Start_mul,
   input  logic        Start_div,
   input  logic        Signed_op,
   input  logic [31:0] Operand_a,
   input  logic [31:0] Operand_b,
   input  logic        Mthi,
   input  logic        Mtlo,
   input  logic        Mfhi,
   input  logic        Mflo,
   input  logic        Flush,
   output logic [31:0] Mul_a,
   output logic [31:0] Mul_b,
   input  logic [63:0] Mul_p,
   output logic        Div_tvalid,
   output logic [31:0] Div_dividend,
   output logic [31:0] Div_divisor,
   input  logic        Div_dout_tvalid,
   input  logic [63:0] Div_dout_tdata,
   output logic [31:0] Hi,
   output logic [31:0] Lo,
   output logic [31:0] Hilo_read_data,
   output logic        Stall,
   output logic        Busy,
   output logic        Divide_zero
);

   typedef enum logic [2:0] {
      IDLE,
      MUL_WAIT,
      DIV_ISSUE,
      DIV_WAIT,
      DRAIN
   } state_t;

   state_t      state, state_next;
   logic [3:0]  cnt, cnt_next;
   logic [31:0] mag_a, mag_b;
   logic        neg_prod, neg_rem;
   logic [31:0] hi_q, lo_q;
   logic        dz_q;

   logic [31:0] abs_a, abs_b;
   logic        latch_en;
   logic        hi_we, lo_we;
   logic [31:0] hi_d, lo_d;
   logic        dz_d;
   logic [63:0] prod_fix;
   logic [31:0] quot_fix, rem_fix;

   assign abs_a = (Signed_op && Operand_a[31]) ? -Operand_a : Operand_a;
   assign abs_b = (Signed_op && Operand_b[31]) ? -Operand_b : Operand_b;

   // Sign post-processing: the quotient takes the XOR of the operand signs,
   // and the remainder takes the sign of the dividend.
   assign prod_fix = neg_prod ? -Mul_p : Mul_p;
   assign quot_fix = neg_prod ? -Div_dout_tdata[63:32] : Div_dout_tdata[63:32];
   assign rem_fix  = neg_rem  ? -Div_dout_tdata[31:0]  : Div_dout_tdata[31:0];

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   always_comb begin
      state_next     = state;
      cnt_next       = cnt;
      latch_en       = 1'b0;
      hi_we          = 1'b0;
      lo_we          = 1'b0;
      hi_d           = hi_q;
      lo_d           = lo_q;
      dz_d           = 1'b0;
      Busy           = (state != IDLE);
      Div_tvalid     = (state == DIV_ISSUE);
      Stall          = Busy & (Start_mul | Start_div | Mthi | Mtlo | Mfhi | Mflo);
      Hilo_read_data = '0;
      if (Mfhi)
         Hilo_read_data = hi_q;
      else if (Mflo)
         Hilo_read_data = lo_q;

      case (state)
         IDLE: begin
            if (!Flush) begin
               if (Start_mul) begin
                  latch_en   = 1'b1;
                  cnt_next   = 4'(MUL_LATENCY);
                  state_next = MUL_WAIT;
               end else if (Start_div) begin
                  latch_en = 1'b1;
                  // A zero divisor never reaches the divider.
                  if (abs_b == '0)
                     dz_d = 1'b1;
                  else
                     state_next = DIV_ISSUE;
               end else begin
                  if (Mthi) begin
                     hi_we = 1'b1;
                     hi_d  = Operand_a;
                  end
                  if (Mtlo) begin
                     lo_we = 1'b1;
                     lo_d  = Operand_a;
                  end
               end
            end
         end
         MUL_WAIT: begin
            if (Flush) begin
               state_next = IDLE;
            end else if (cnt == '0) begin
               hi_we      = 1'b1;
               lo_we      = 1'b1;
               hi_d       = prod_fix[63:32];
               lo_d       = prod_fix[31:0];
               state_next = IDLE;
            end else begin
               cnt_next = cnt - 4'd1;
            end
         end
         DIV_ISSUE: begin
            // The divider has accepted the operands this cycle. A flush here
            // still leaves a result in flight.
            if (Flush)
               state_next = DIV_FLUSH_DRAIN ? DRAIN : IDLE;
            else
               state_next = DIV_WAIT;
         end
         DIV_WAIT: begin
            if (Flush) begin
               // If the result arrives in the same cycle as the flush, the
               // result is consumed here, so no drain is needed.
               if (Div_dout_tvalid || !DIV_FLUSH_DRAIN)
                  state_next = IDLE;
               else
                  state_next = DRAIN;
            end else if (Div_dout_tvalid) begin
               hi_we      = 1'b1;
               lo_we      = 1'b1;
               hi_d       = rem_fix;
               lo_d       = quot_fix;
               state_next = IDLE;
            end
         end
         DRAIN: begin
            if (Div_dout_tvalid)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         mag_a    <= '0;
         mag_b    <= '0;
         neg_prod <= 1'b0;
         neg_rem  <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         dz_q     <= 1'b0;
      end else begin
         dz_q <= dz_d;
         if (latch_en) begin
            mag_a    <= abs_a;
            mag_b    <= abs_b;
            neg_prod <= Signed_op & (Operand_a[31] ^ Operand_b[31]);
            neg_rem  <= Signed_op & Operand_a[31];
         end
         if (hi_we)
            hi_q <= hi_d;
         if (lo_we)
            lo_q <= lo_d;
      end
   end

   assign Mul_a        = mag_a;
   assign Mul_b        = mag_b;
   assign Div_dividend = mag_a;
   assign Div_divisor  = mag_b;
   assign Hi           = hi_q;
   assign Lo           = lo_q;
   assign Divide_zero  = dz_q;

endmodule
